// File: rtl/stage_sequencer_if.sv
// Bus bundle between the learning-core stages and the stage sequencer.
// The master side drives control/request inputs; the slave side is the sequencer.
interface stage_sequencer_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  en;
    logic                  start;
    logic [7:0]            stage_done;
    logic [7:0]            stage_rd_req;
    logic [WORD_WIDTH-1:0] mem_rd_data;
    logic [2:0]            sel;
    logic [7:0]            stage_start;
    logic [7:0]            rd_valid;
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  busy;
    logic                  iter_done;
    logic [15:0]           iter_count;

    modport master (
        output en, start, stage_done, stage_rd_req, mem_rd_data,
        input  sel, stage_start, rd_valid, rd_data, busy, iter_done, iter_count
    );

    modport slave (
        input  en, start, stage_done, stage_rd_req, mem_rd_data,
        output sel, stage_start, rd_valid, rd_data, busy, iter_done, iter_count
    );
endinterface

// File: rtl/stage_sequencer.sv
// Steps the learning core through its eight stages in fixed order and routes
// synchronous memory read data back to the stage that issued each read.
module stage_sequencer #(
    parameter int WORD_WIDTH = 16
) (
    input  logic             clock,
    input  logic             nrst,
    stage_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [2:0]            k_r;
    logic [2:0]            k_nxt_s;
    logic [15:0]           iter_count_r;
    logic                  accept_s;
    logic                  req_vld_r;
    logic [2:0]            req_tag_r;
    logic [7:0]            rd_valid_r;
    logic [WORD_WIDTH-1:0] rd_data_r;
    logic [7:0]            stage_start_s;
    logic [7:0]            rd_valid_s;
    logic                  iter_done_s;

    function automatic logic [7:0] stage_onehot(input logic [2:0] idx);
        logic [7:0] oh;
        oh      = 8'h00;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Next-state and stage index; stage_done is only looked at for the active stage in RUN
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_START;
                    k_nxt_s     = 3'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.stage_done[k_r]) begin
                    state_nxt_s = ST_RUN;
                end else if (k_r == 3'd7) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_START;
                    k_nxt_s     = k_r + 3'd1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                k_nxt_s     = 3'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                k_nxt_s     = 3'd0;
            end
        endcase
    end

    // State, stage index and iteration counter, all frozen while en is low
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_r      <= ST_IDLE;
            k_r          <= 3'd0;
            iter_count_r <= 16'd0;
        end else if (bus.en) begin
            state_r <= state_nxt_s;
            k_r     <= k_nxt_s;
            if (state_r == ST_DONE) begin
                iter_count_r <= iter_count_r + 16'd1;
            end
        end
    end

    // Only the active stage's request is accepted, and only while a stage is live
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == ST_START) || (state_r == ST_RUN)) begin
            accept_s = bus.stage_rd_req[k_r];
        end else begin
            accept_s = 1'b0;
        end
    end

    // Two-stage read pipeline: tag at request, capture data one cycle later
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            req_vld_r  <= 1'b0;
            req_tag_r  <= 3'd0;
            rd_valid_r <= 8'h00;
            rd_data_r  <= '0;
        end else if (bus.en) begin
            req_vld_r <= accept_s;
            if (accept_s) begin
                req_tag_r <= k_r;
            end
            if (req_vld_r) begin
                rd_valid_r <= stage_onehot(req_tag_r);
                rd_data_r  <= bus.mem_rd_data;
            end else begin
                rd_valid_r <= 8'h00;
            end
        end
    end

    // Pulse outputs decode registered state; en low masks them without losing them
    always_comb begin
        stage_start_s = 8'h00;
        rd_valid_s    = 8'h00;
        iter_done_s   = 1'b0;
        if (bus.en) begin
            stage_start_s = (state_r == ST_START) ? stage_onehot(k_r) : 8'h00;
            rd_valid_s    = rd_valid_r;
            iter_done_s   = (state_r == ST_DONE);
        end else begin
            stage_start_s = 8'h00;
            rd_valid_s    = 8'h00;
            iter_done_s   = 1'b0;
        end
    end

    assign bus.sel         = k_r;
    assign bus.busy        = (state_r != ST_IDLE);
    assign bus.stage_start = stage_start_s;
    assign bus.rd_valid    = rd_valid_s;
    assign bus.rd_data     = rd_data_r;
    assign bus.iter_done   = iter_done_s;
    assign bus.iter_count  = iter_count_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a table-driven single iteration followed
// by hand-written sequences for filtering, read routing, enable freeze, wrap and reset.
module tb_stage_sequencer;

    logic clock;
    logic nrst;
    int   pass_cnt;
    int   total_cnt;

    stage_sequencer_if #(.WORD_WIDTH(16)) bus ();

    stage_sequencer #(.WORD_WIDTH(16)) dut (
        .clock (clock),
        .nrst  (nrst),
        .bus   (bus)
    );

    typedef struct {
        logic        start;
        logic [7:0]  done;
        logic [2:0]  exp_sel;
        logic [7:0]  exp_ss;
        logic        exp_busy;
        logic        exp_iter_done;
        logic [15:0] exp_count;
    } vec_t;

    vec_t tbl [19];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Entered in START of stage k, leaves in START of k+1 (or DONE for k=7)
    task automatic finish_stage(input int k);
        tick();
        bus.stage_done    = 8'h00;
        bus.stage_done[k] = 1'b1;
        tick();
        bus.stage_done = 8'h00;
    endtask

    task automatic begin_iter();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [7:0] oh;
        pass_cnt  = 0;
        total_cnt = 0;
        nrst      = 1'b0;
        bus.en           = 1'b1;
        bus.start        = 1'b0;
        bus.stage_done   = 8'h00;
        bus.stage_rd_req = 8'h00;
        bus.mem_rd_data  = 16'h0000;

        tbl[0] = '{start: 1'b1, done: 8'hFF, exp_sel: 3'd0, exp_ss: 8'h00,
                   exp_busy: 1'b0, exp_iter_done: 1'b0, exp_count: 16'd0};
        for (int k = 0; k < 8; k++) begin
            oh    = 8'h00;
            oh[k] = 1'b1;
            tbl[2*k+1] = '{start: 1'b0, done: 8'hFF, exp_sel: 3'(k), exp_ss: oh,
                           exp_busy: 1'b1, exp_iter_done: 1'b0, exp_count: 16'd0};
            tbl[2*k+2] = '{start: 1'b0, done: 8'hFF, exp_sel: 3'(k), exp_ss: 8'h00,
                           exp_busy: 1'b1, exp_iter_done: 1'b0, exp_count: 16'd0};
        end
        tbl[17] = '{start: 1'b0, done: 8'hFF, exp_sel: 3'd7, exp_ss: 8'h00,
                    exp_busy: 1'b1, exp_iter_done: 1'b1, exp_count: 16'd0};
        tbl[18] = '{start: 1'b0, done: 8'hFF, exp_sel: 3'd0, exp_ss: 8'h00,
                    exp_busy: 1'b0, exp_iter_done: 1'b0, exp_count: 16'd1};

        // Reset values
        tick();
        tick();
        chk("reset_sel", 32'(bus.sel), 32'd0);
        chk("reset_stage_start", 32'(bus.stage_start), 32'd0);
        chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_iter_done", 32'(bus.iter_done), 32'd0);
        chk("reset_iter_count", 32'(bus.iter_count), 32'd0);
        nrst = 1'b1;

        // Single iteration with every stage_done held high
        for (int i = 0; i < 19; i++) begin
            bus.start      = tbl[i].start;
            bus.stage_done = tbl[i].done;
            settle();
            chk($sformatf("iter_sel[%0d]", i), 32'(bus.sel), 32'(tbl[i].exp_sel));
            chk($sformatf("iter_stage_start[%0d]", i), 32'(bus.stage_start), 32'(tbl[i].exp_ss));
            chk($sformatf("iter_busy[%0d]", i), 32'(bus.busy), 32'(tbl[i].exp_busy));
            chk($sformatf("iter_done[%0d]", i), 32'(bus.iter_done), 32'(tbl[i].exp_iter_done));
            chk($sformatf("iter_count[%0d]", i), 32'(bus.iter_count), 32'(tbl[i].exp_count));
            chk($sformatf("iter_rd_valid[%0d]", i), 32'(bus.rd_valid), 32'd0);
            tick();
        end
        bus.stage_done = 8'h00;

        // Done filtering in stage 2
        begin_iter();
        finish_stage(0);
        finish_stage(1);
        tick();
        bus.stage_done = 8'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("filter_sel[%0d]", i), 32'(bus.sel), 32'd2);
            chk($sformatf("filter_stage_start[%0d]", i), 32'(bus.stage_start), 32'd0);
        end
        bus.stage_done = 8'h04;
        tick();
        bus.stage_done = 8'h00;

        // Enable freeze during START of stage 3
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("freeze_stage_start[%0d]", i), 32'(bus.stage_start), 32'd0);
            chk($sformatf("freeze_sel[%0d]", i), 32'(bus.sel), 32'd3);
            tick();
        end
        bus.en = 1'b1;
        settle();
        chk("unfreeze_stage_start", 32'(bus.stage_start), 32'h08);
        tick();
        chk("unfreeze_no_repeat", 32'(bus.stage_start), 32'h00);
        chk("unfreeze_sel", 32'(bus.sel), 32'd3);
        bus.stage_done = 8'h08;
        tick();
        bus.stage_done = 8'h00;

        // Read routing in stage 4, back-to-back requests plus a foreign request
        chk("route_stage4_start", 32'(bus.stage_start), 32'h10);
        bus.stage_rd_req = 8'h30;
        bus.mem_rd_data  = 16'h0000;
        tick();
        bus.mem_rd_data = 16'h00A1;
        settle();
        chk("route_rv_c1", 32'(bus.rd_valid), 32'h00);
        tick();
        bus.mem_rd_data = 16'h00A2;
        settle();
        chk("route_rv_c2", 32'(bus.rd_valid), 32'h10);
        chk("route_data_c2", 32'(bus.rd_data), 32'h00A1);
        tick();
        bus.stage_rd_req = 8'h00;
        bus.mem_rd_data  = 16'h00A3;
        settle();
        chk("route_rv_c3", 32'(bus.rd_valid), 32'h10);
        chk("route_data_c3", 32'(bus.rd_data), 32'h00A2);
        tick();
        bus.mem_rd_data = 16'hBEEF;
        settle();
        chk("route_rv_c4", 32'(bus.rd_valid), 32'h10);
        chk("route_data_c4", 32'(bus.rd_data), 32'h00A3);
        tick();
        bus.stage_rd_req = 8'h20;
        settle();
        chk("route_rv_c5", 32'(bus.rd_valid), 32'h00);
        chk("route_hold_c5", 32'(bus.rd_data), 32'h00A3);
        tick();
        bus.stage_rd_req = 8'h00;
        tick();
        chk("route_foreign_rv", 32'(bus.rd_valid), 32'h00);
        chk("route_foreign_data", 32'(bus.rd_data), 32'h00A3);
        bus.mem_rd_data = 16'h0000;
        bus.stage_done  = 8'h10;
        tick();
        bus.stage_done = 8'h00;

        // In-flight read across the stage 6 to 7 transition
        finish_stage(5);
        tick();
        bus.stage_done   = 8'h40;
        bus.stage_rd_req = 8'h40;
        tick();
        bus.stage_done   = 8'h00;
        bus.stage_rd_req = 8'h00;
        bus.mem_rd_data  = 16'h00C6;
        settle();
        chk("inflight_rv_early", 32'(bus.rd_valid), 32'h00);
        chk("inflight_stage7_start", 32'(bus.stage_start), 32'h80);
        tick();
        bus.mem_rd_data = 16'h0000;
        settle();
        chk("inflight_rv", 32'(bus.rd_valid), 32'h40);
        chk("inflight_data", 32'(bus.rd_data), 32'h00C6);
        chk("inflight_sel", 32'(bus.sel), 32'd7);
        bus.stage_done = 8'h80;
        tick();
        bus.stage_done = 8'h00;
        chk("iter2_done", 32'(bus.iter_done), 32'd1);
        tick();
        chk("iter2_count", 32'(bus.iter_count), 32'd2);
        chk("iter2_busy", 32'(bus.busy), 32'd0);

        // Counter wrap, with start held outside IDLE to show it is not queued
        force dut.iter_count_r = 16'hFFFF;
        tick();
        release dut.iter_count_r;
        settle();
        chk("wrap_preload", 32'(bus.iter_count), 32'hFFFF);
        bus.stage_done = 8'hFF;
        bus.start      = 1'b1;
        tick();
        for (int i = 2; i <= 17; i++) begin
            tick();
            if (i == 16) begin
                bus.start = 1'b0;
            end
        end
        chk("wrap_iter_done", 32'(bus.iter_done), 32'd1);
        tick();
        chk("wrap_count", 32'(bus.iter_count), 32'd0);
        chk("wrap_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("wrap_no_queued_start", 32'(bus.busy), 32'd0);
        chk("wrap_no_stage_start", 32'(bus.stage_start), 32'd0);
        bus.stage_done = 8'h00;

        // Reset during stage 5 RUN with a read in flight
        begin_iter();
        for (int k = 0; k < 5; k++) begin
            finish_stage(k);
        end
        tick();
        bus.stage_rd_req = 8'h20;
        bus.mem_rd_data  = 16'h5A5A;
        tick();
        bus.stage_rd_req = 8'h00;
        chk("pre_reset_sel", 32'(bus.sel), 32'd5);
        nrst = 1'b0;
        settle();
        chk("midreset_sel", 32'(bus.sel), 32'd0);
        chk("midreset_stage_start", 32'(bus.stage_start), 32'd0);
        chk("midreset_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("midreset_rd_data", 32'(bus.rd_data), 32'd0);
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        chk("midreset_iter_done", 32'(bus.iter_done), 32'd0);
        chk("midreset_iter_count", 32'(bus.iter_count), 32'd0);
        tick();
        tick();
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("postreset_rv[%0d]", i), 32'(bus.rd_valid), 32'd0);
            chk($sformatf("postreset_busy[%0d]", i), 32'(bus.busy), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
